// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared defaults and FSM state encoding for mem_arbiter
package mem_arb_pkg;

   localparam int ADDR_W_DEF    = 16;
   localparam int DATA_W_DEF    = 16;
   localparam int MEM_DEPTH_DEF = 256;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_ACCESS = 2'd1;
   localparam state_t ST_WAIT   = 2'd2;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - two-request round-robin picker, one-hot grant
module rr_arb2 (
   input  logic [1:0] req_i,     // [0] fetch, [1] data
   input  logic       last_d_i,  // 1 when the data port was served last
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = req_i;
      if (req_i == 2'b11) begin
         gnt_o = last_d_i ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch and data ports onto one registered memory port
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

   state_t            state_q, state_d;
   logic              last_d_q, last_d_d;
   logic              own_d_q, own_d_d;    // port owning the in-flight access
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_data_q, mem_data_d;
   logic              mem_write_q, mem_write_d;
   logic              mem_read_q, mem_read_d;
   logic              if_done_q, if_done_d;
   logic              if_err_q, if_err_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic              d_done_q, d_done_d;
   logic              d_err_q, d_err_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   logic [1:0]        req_elig;
   logic [1:0]        gnt;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_ok;

   // A held request is masked during its own done cycle so it is not granted twice.
   assign req_elig = {d_req & ~d_done_q, if_req & ~if_done_q};

   rr_arb2 u_rr (
      .req_i    (req_elig),
      .last_d_i (last_d_q),
      .gnt_o    (gnt)
   );

   assign sel_addr = gnt[1] ? d_addr : if_addr;
   assign sel_ok   = {1'b0, sel_addr} < DEPTH_L;

   always_comb begin
      state_d     = state_q;
      last_d_d    = last_d_q;
      own_d_d     = own_d_q;
      mem_addr_d  = mem_addr_q;
      mem_data_d  = mem_data_q;
      mem_write_d = 1'b0;
      mem_read_d  = 1'b0;
      if_done_d   = 1'b0;
      if_err_d    = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_done_d    = 1'b0;
      d_err_d     = 1'b0;
      d_rdata_d   = d_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt != 2'b00) begin
               last_d_d = gnt[1];
               own_d_d  = gnt[1];
               if (sel_ok) begin
                  mem_addr_d  = sel_addr;
                  mem_data_d  = gnt[1] ? d_wdata : '0;
                  mem_write_d = gnt[1] & d_we;
                  mem_read_d  = ~(gnt[1] & d_we);
                  state_d     = ST_ACCESS;
               end else if (gnt[1]) begin
                  d_done_d = 1'b1;
                  d_err_d  = 1'b1;
               end else begin
                  if_done_d = 1'b1;
                  if_err_d  = 1'b1;
               end
            end
         end
         ST_ACCESS: begin
            if (mem_write_q) begin
               d_done_d = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (own_d_q) begin
               d_rdata_d = mem_rdata;
               d_done_d  = 1'b1;
            end else begin
               if_rdata_d = mem_rdata;
               if_done_d  = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         last_d_q    <= 1'b1;
         own_d_q     <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         mem_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         if_done_q   <= 1'b0;
         if_err_q    <= 1'b0;
         if_rdata_q  <= '0;
         d_done_q    <= 1'b0;
         d_err_q     <= 1'b0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         last_d_q    <= last_d_d;
         own_d_q     <= own_d_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
         mem_write_q <= mem_write_d;
         mem_read_q  <= mem_read_d;
         if_done_q   <= if_done_d;
         if_err_q    <= if_err_d;
         if_rdata_q  <= if_rdata_d;
         d_done_q    <= d_done_d;
         d_err_q     <= d_err_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign if_done   = if_done_q;
   assign if_err    = if_err_q;
   assign if_rdata  = if_rdata_q;
   assign d_done    = d_done_q;
   assign d_err     = d_err_q;
   assign d_rdata   = d_rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_data  = mem_data_q;
   assign mem_write = mem_write_q;
   assign mem_read  = mem_read_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with memory and reference model
module tb_mem_arbiter;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [15:0] if_addr = '0;
   logic        if_done;
   logic [15:0] if_rdata;
   logic        if_err;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [15:0] d_addr = '0;
   logic [15:0] d_wdata = '0;
   logic        d_done;
   logic [15:0] d_rdata;
   logic        d_err;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic        mem_write;
   logic        mem_read;
   logic [15:0] mem_rdata = '0;
   logic        busy;

   logic [15:0] mem     [0:DEPTH-1];
   logic [15:0] ref_mem [0:DEPTH-1];
   logic [15:0] if_hold = '0;
   logic [15:0] d_hold = '0;
   int          checks = 0;
   int          failures = 0;
   int          rd_pulses = 0;
   int          wr_pulses = 0;
   int          d_done_cnt = 0;
   int          done_log[$];

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write), .mem_read(mem_read),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_write) mem[mem_addr[7:0]] <= mem_data;
      if (mem_read)  mem_rdata <= mem[mem_addr[7:0]];
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check_val("one_done", {31'd0, if_done & d_done}, 32'd0);
         check_val("rw_excl", {31'd0, mem_read & mem_write}, 32'd0);
         if (mem_read || mem_write) check_val("busy_strobe", {31'd0, busy}, 32'd1);
         if (mem_read)  rd_pulses++;
         if (mem_write) wr_pulses++;
         if (if_done) done_log.push_back(0);
         if (d_done) begin
            done_log.push_back(1);
            d_done_cnt++;
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      if_req = 1'b0;
      d_req = 1'b0;
      if_hold = '0;
      d_hold = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic fetch_txn(input logic [15:0] addr, output int lat);
      logic        oor;
      logic [15:0] exp;
      oor = (int'(addr) >= DEPTH);
      exp = oor ? if_hold : ref_mem[addr[7:0]];
      if_addr = addr;
      if_req = 1'b1;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!if_done && lat < 20);
      check_val("if_done", {31'd0, if_done}, 32'd1);
      check_val("if_err", {31'd0, if_err}, {31'd0, oor});
      check_val("if_rdata", {16'd0, if_rdata}, {16'd0, exp});
      if (!oor) if_hold = exp;
      @(posedge clk);
      #1 if_req = 1'b0;
   endtask

   task automatic data_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           output int lat);
      logic        oor;
      logic [15:0] exp;
      oor = (int'(addr) >= DEPTH);
      exp = (oor || we) ? d_hold : ref_mem[addr[7:0]];
      d_we = we;
      d_addr = addr;
      d_wdata = wdata;
      d_req = 1'b1;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!d_done && lat < 20);
      check_val("d_done", {31'd0, d_done}, 32'd1);
      check_val("d_err", {31'd0, d_err}, {31'd0, oor});
      check_val("d_rdata", {16'd0, d_rdata}, {16'd0, exp});
      if (!oor && we)  ref_mem[addr[7:0]] = wdata;
      if (!oor && !we) d_hold = exp;
      @(posedge clk);
      #1 d_req = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, rd0, wr0, dc0;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[3] = 16'h1234;
      ref_mem[3] = 16'h1234;

      #12;
      check_val("rst_outs", {mem_addr, mem_data}, 32'd0);
      check_val("rst_rdata", {if_rdata, d_rdata}, 32'd0);
      check_val("rst_flags", {26'd0, if_done, if_err, d_done, d_err, mem_write, mem_read}, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // fetch read, first grant right after reset
      rd0 = rd_pulses;
      fetch_txn(16'h0003, lat);
      check_val("f_rd_lat", lat, 3);
      check_val("f_rd_pulse", rd_pulses - rd0, 1);
      check_val("f_rd_val", {16'd0, if_rdata}, 32'h1234);

      // data write then read back
      wr0 = wr_pulses;
      data_txn(1'b1, 16'h0010, 16'hBEEF, lat);
      check_val("d_wr_lat", lat, 2);
      check_val("d_wr_pulse", wr_pulses - wr0, 1);
      check_val("d_wr_mem", {16'd0, mem[16]}, 32'hBEEF);
      data_txn(1'b0, 16'h0010, 16'h0000, lat);
      check_val("d_rd_lat", lat, 3);
      check_val("d_rd_val", {16'd0, d_rdata}, 32'hBEEF);

      // out-of-range on both ports
      rd0 = rd_pulses;
      wr0 = wr_pulses;
      data_txn(1'b0, 16'h0100, 16'h0000, lat);
      check_val("d_oor_lat", lat, 1);
      data_txn(1'b1, 16'hFFFF, 16'h5A5A, lat);
      check_val("d_oor_wlat", lat, 1);
      fetch_txn(16'h0200, lat);
      check_val("f_oor_lat", lat, 1);
      check_val("oor_no_rd", rd_pulses - rd0, 0);
      check_val("oor_no_wr", wr_pulses - wr0, 0);

      // both held continuously: alternate grants, dropped in-flight access still completes
      do_reset();
      done_log.delete();
      if_addr = 16'h000A;
      d_addr = 16'h0014;
      d_we = 1'b0;
      if_req = 1'b1;
      d_req = 1'b1;
      repeat (14) @(posedge clk);
      #1;
      if_req = 1'b0;
      d_req = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check_val("alt_count", done_log.size(), 5);
      for (int i = 0; i < 5 && i < done_log.size(); i++) begin
         check_val($sformatf("alt_order%0d", i), done_log[i], i % 2);
      end
      check_val("alt_if_rdata", {16'd0, if_rdata}, {16'd0, ref_mem[10]});
      check_val("alt_d_rdata", {16'd0, d_rdata}, {16'd0, ref_mem[20]});

      // reset during the memory access of a write
      mem[5] = 16'h5555;
      ref_mem[5] = 16'h5555;
      dc0 = d_done_cnt;
      d_we = 1'b1;
      d_addr = 16'h0005;
      d_wdata = 16'h00AA;
      d_req = 1'b1;
      @(posedge clk);
      #2;
      check_val("rst_mid_pre", {31'd0, mem_write}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_val("rst_mid_wr", {31'd0, mem_write}, 32'd0);
      check_val("rst_mid_busy", {31'd0, busy}, 32'd0);
      d_req = 1'b0;
      if_hold = '0;
      d_hold = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_mid_mem", {16'd0, mem[5]}, 32'h5555);
      check_val("rst_mid_done", d_done_cnt - dc0, 0);

      // randomized concurrent traffic; data writes stay out of the fetch region
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               logic [15:0] a;
               int          l;
               repeat ($urandom_range(0, 3)) begin
                  @(posedge clk);
                  #1;
               end
               a = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(256, 65535))
                                                : 16'($urandom_range(0, 127));
               fetch_txn(a, l);
               check_val("f_lat_bound", {31'd0, l <= 6}, 32'd1);
            end
         end
         begin
            for (int i = 0; i < 40; i++) begin
               logic [15:0] a;
               logic        w;
               int          l;
               repeat ($urandom_range(0, 3)) begin
                  @(posedge clk);
                  #1;
               end
               w = 1'($urandom_range(0, 1));
               if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(256, 65535));
               else if (w)                    a = 16'($urandom_range(128, 255));
               else                           a = 16'($urandom_range(0, 255));
               data_txn(w, a, 16'($urandom), l);
               check_val("d_lat_bound", {31'd0, l <= 6}, 32'd1);
            end
         end
      join

      repeat (4) @(posedge clk);
      for (int i = 128; i < DEPTH; i++) begin
         if (mem[i] !== ref_mem[i]) check_val($sformatf("final_mem%0d", i), {16'd0, mem[i]}, {16'd0, ref_mem[i]});
      end
      check_val("final_mem_any", {16'd0, mem[200]}, {16'd0, ref_mem[200]});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
